lfsr_checker: RTL and testbench

- Receive-side checker for the 8-bit XNOR LFSR pseudo-random generator.
- Samples the generator's 8-bit output words and hunts for sequence alignment.
- After locking, runs a free-running internal copy of the LFSR (flywheel) and reports mismatches, loss of lock, sequence period and lockup-state words.
- Sits next to the generator in loopback and board self-test paths, in the same clock domain.

---
 rtl/lfsr_checker_if.sv | 16 +
 rtl/lfsr_checker.sv | 235 +++++++++++++++++++++++
 tb/tb_lfsr_checker.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// ----------------------------------------------------------------------------
// lfsr_checker_if
// Word stream from the 8-bit XNOR LFSR generator into its receive-side checker.
//   in_valid : in_data holds a new generator word this cycle
//   in_data  : generator output word
// Modports:
//   master : generator side, drives the stream
//   slave  : checker side, samples the stream
// ----------------------------------------------------------------------------
interface lfsr_checker_if;
  logic       in_valid;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/lfsr_checker.sv
// ----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the 8-bit XNOR LFSR generator. Hunts for sequence
// alignment, then runs a free-running copy of the LFSR (flywheel) and reports
// mismatches, loss of lock, the sequence period and lockup-state words.
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_if        : generator word stream (in_valid / in_data), slave side
//   clr_stats    : synchronous clear of err_count, lockup_flag, period_len
//   locked       : high while aligned to the stream
//   err_pulse    : one-cycle pulse per mismatched word while locked
//   err_count    : saturating count of mismatches while locked
//   period_pulse : one-cycle pulse when the flywheel returns to its reference
//   period_len   : valid words in the last completed period, saturates at 511
//   lockup_flag  : sticky, set by any valid 8'hFF word
// All outputs are registered; a sampled word shows its effect next cycle.
// ----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lfsr_checker_if.slave    in_if,
  input  logic             clr_stats,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             period_pulse,
  output logic [8:0]       period_len,
  output logic             lockup_flag
);

  typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0]       LOCK_CNT_C   = 4'(LOCK_CNT);
  localparam logic [3:0]       UNLOCK_CNT_C = 4'(UNLOCK_CNT);
  localparam logic [7:0]       LOCKUP_WORD  = 8'hFF;
  localparam logic [8:0]       PER_MAX      = 9'd511;
  localparam logic [ERR_W-1:0] ERR_MAX      = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE      = {{(ERR_W-1){1'b0}}, 1'b1};

  // One step of the generator: shift left, XNOR feedback from taps 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    lfsr_next = {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
  endfunction

  state_t           state_r, state_s;
  logic [7:0]       prev_r, prev_s;
  logic             prev_valid_r, prev_valid_s;
  logic [3:0]       match_cnt_r, match_cnt_s;
  logic [3:0]       miss_cnt_r, miss_cnt_s;
  logic [7:0]       exp_r, exp_s;
  logic [7:0]       ref_r, ref_s;
  logic [8:0]       per_cnt_r, per_cnt_s;

  logic             locked_r, locked_s;
  logic             err_pulse_r, err_pulse_s;
  logic [ERR_W-1:0] err_count_r, err_count_s;
  logic             period_pulse_r, period_pulse_s;
  logic [8:0]       period_len_r, period_len_s;
  logic             lockup_flag_r, lockup_flag_s;

  logic             valid_s;
  logic [7:0]       word_s;
  logic [7:0]       fly_next_s;
  logic             hunt_hit_s;
  logic             fly_hit_s;
  logic             ref_hit_s;
  logic             lock_evt_s;
  logic             unlock_evt_s;

  assign valid_s    = in_if.in_valid;
  assign word_s     = in_if.in_data;
  assign fly_next_s = lfsr_next(exp_r);
  // The lockup word predicts itself, so it must be excluded explicitly or a
  // stuck-high stream would lock.
  assign hunt_hit_s = prev_valid_r && (word_s == lfsr_next(prev_r)) && (word_s != LOCKUP_WORD);
  assign fly_hit_s  = (word_s == fly_next_s);
  assign ref_hit_s  = (fly_next_s == ref_r);
  assign lock_evt_s = valid_s && (state_r == HUNT) && hunt_hit_s &&
                      ((match_cnt_r + 4'd1) == LOCK_CNT_C);
  assign unlock_evt_s = valid_s && (state_r == LOCKED) && !fly_hit_s &&
                        ((miss_cnt_r + 4'd1) == UNLOCK_CNT_C);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision: lock on enough consecutive predictions, unlock on enough misses.
  always_comb begin
    state_s = state_r;
    case (state_r)
      HUNT:    if (lock_evt_s)   state_s = LOCKED; else state_s = HUNT;
      LOCKED:  if (unlock_evt_s) state_s = HUNT;   else state_s = LOCKED;
      default: state_s = HUNT;
    endcase
  end

  // Next values of the hunt history, counters and flywheel.
  always_comb begin
    prev_s       = prev_r;
    prev_valid_s = prev_valid_r;
    match_cnt_s  = match_cnt_r;
    miss_cnt_s   = miss_cnt_r;
    exp_s        = exp_r;
    ref_s        = ref_r;
    per_cnt_s    = per_cnt_r;
    if (valid_s) begin
      case (state_r)
        HUNT: begin
          prev_s       = word_s;
          prev_valid_s = 1'b1;
          // The first word after hunt entry only seeds the predictor.
          if (!prev_valid_r)   match_cnt_s = match_cnt_r;
          else if (hunt_hit_s) match_cnt_s = match_cnt_r + 4'd1;
          else                 match_cnt_s = 4'd0;
          if (lock_evt_s) begin
            exp_s      = word_s;
            ref_s      = word_s;
            per_cnt_s  = 9'd0;
            miss_cnt_s = 4'd0;
          end else begin
            miss_cnt_s = miss_cnt_r;
          end
        end
        LOCKED: begin
          // Flywheel advances whether or not the word matched.
          exp_s = fly_next_s;
          if (ref_hit_s)                per_cnt_s = 9'd0;
          else if (per_cnt_r == PER_MAX) per_cnt_s = PER_MAX;
          else                          per_cnt_s = per_cnt_r + 9'd1;
          if (fly_hit_s) miss_cnt_s = 4'd0;
          else           miss_cnt_s = miss_cnt_r + 4'd1;
          if (unlock_evt_s) begin
            prev_valid_s = 1'b0;
            match_cnt_s  = 4'd0;
          end else begin
            prev_valid_s = prev_valid_r;
          end
        end
        default: begin
          prev_valid_s = 1'b0;
          match_cnt_s  = 4'd0;
        end
      endcase
    end else begin
      prev_s = prev_r;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r       <= 8'h00;
      prev_valid_r <= 1'b0;
      match_cnt_r  <= 4'd0;
      miss_cnt_r   <= 4'd0;
      exp_r        <= 8'h00;
      ref_r        <= 8'h00;
      per_cnt_r    <= 9'd0;
    end else begin
      prev_r       <= prev_s;
      prev_valid_r <= prev_valid_s;
      match_cnt_r  <= match_cnt_s;
      miss_cnt_r   <= miss_cnt_s;
      exp_r        <= exp_s;
      ref_r        <= ref_s;
      per_cnt_r    <= per_cnt_s;
    end
  end

  // Next values of the reported status and statistics; a clear beats same-cycle events.
  always_comb begin
    locked_s       = (state_s == LOCKED);
    err_pulse_s    = 1'b0;
    period_pulse_s = 1'b0;
    err_count_s    = err_count_r;
    period_len_s   = period_len_r;
    lockup_flag_s  = lockup_flag_r;
    if (valid_s && (state_r == LOCKED)) begin
      err_pulse_s    = !fly_hit_s;
      period_pulse_s = ref_hit_s;
      if (!fly_hit_s && (err_count_r != ERR_MAX)) err_count_s = err_count_r + ERR_ONE;
      else                                         err_count_s = err_count_r;
      if (ref_hit_s) period_len_s = (per_cnt_r == PER_MAX) ? PER_MAX : (per_cnt_r + 9'd1);
      else           period_len_s = period_len_r;
    end else begin
      err_pulse_s = 1'b0;
    end
    if (valid_s && (word_s == LOCKUP_WORD)) lockup_flag_s = 1'b1;
    else                                    lockup_flag_s = lockup_flag_r;
    if (clr_stats) begin
      err_count_s   = {ERR_W{1'b0}};
      period_len_s  = 9'd0;
      lockup_flag_s = 1'b0;
    end else begin
      period_pulse_s = period_pulse_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_r       <= 1'b0;
      err_pulse_r    <= 1'b0;
      err_count_r    <= {ERR_W{1'b0}};
      period_pulse_r <= 1'b0;
      period_len_r   <= 9'd0;
      lockup_flag_r  <= 1'b0;
    end else begin
      locked_r       <= locked_s;
      err_pulse_r    <= err_pulse_s;
      err_count_r    <= err_count_s;
      period_pulse_r <= period_pulse_s;
      period_len_r   <= period_len_s;
      lockup_flag_r  <= lockup_flag_s;
    end
  end

  assign locked       = locked_r;
  assign err_pulse    = err_pulse_r;
  assign err_count    = err_count_r;
  assign period_pulse = period_pulse_r;
  assign period_len   = period_len_r;
  assign lockup_flag  = lockup_flag_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// ----------------------------------------------------------------------------
// tb_lfsr_checker
// Directed scenarios plus a randomized stream for lfsr_checker. A behavioural
// model (window of recent words while hunting, flywheel position while locked)
// predicts every output; one process compares it with the DUT each cycle.
// ----------------------------------------------------------------------------
module tb_lfsr_checker;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int ERR_W      = 16;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_stats;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             period_pulse;
  logic [8:0]       period_len;
  logic             lockup_flag;

  lfsr_checker_if bus ();

  lfsr_checker #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (bus),
    .clr_stats    (clr_stats),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .period_pulse (period_pulse),
    .period_len   (period_len),
    .lockup_flag  (lockup_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] x);
    logic b;
    b = ~(x[7] ^ x[5] ^ x[4] ^ x[3]);
    return (x << 1) | {7'd0, b};
  endfunction

  // ---------------- behavioural model ----------------
  bit         m_locked;
  logic [7:0] hist[$];
  logic [7:0] m_fly;
  logic [7:0] m_ref;
  int         m_since;
  int         m_miss;
  int         m_err;
  int         m_plen;
  bit         m_lkf;
  bit         m_ep;
  bit         m_pp;

  task automatic model_reset();
    m_locked = 0; hist.delete(); m_fly = 8'h00; m_ref = 8'h00;
    m_since = 0; m_miss = 0; m_err = 0; m_plen = 0; m_lkf = 0; m_ep = 0; m_pp = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    logic [7:0] e;
    bit chain;
    m_ep = 0;
    m_pp = 0;
    if (v) begin
      if (d == 8'hFF) m_lkf = 1;
      if (!m_locked) begin
        // Lock once the last LOCK_CNT+1 words since hunt entry form an LFSR chain.
        hist.push_back(d);
        if (hist.size() > LOCK_CNT + 1) void'(hist.pop_front());
        if (hist.size() == LOCK_CNT + 1) begin
          chain = 1;
          for (int i = 1; i <= LOCK_CNT; i++)
            if (hist[i] != nxt(hist[i-1]) || hist[i] == 8'hFF) chain = 0;
          if (chain) begin
            m_locked = 1; m_fly = d; m_ref = d; m_since = 0; m_miss = 0; hist.delete();
          end
        end
      end else begin
        e = nxt(m_fly);
        m_fly = e;
        m_since = (m_since < 511) ? m_since + 1 : 511;
        if (d != e) begin
          m_ep = 1;
          if (m_err < ERR_MAX) m_err++;
          m_miss++;
          if (m_miss == UNLOCK_CNT) begin
            m_locked = 0;
            hist.delete();
          end
        end else begin
          m_miss = 0;
        end
        if (e == m_ref) begin
          m_pp = 1; m_plen = m_since; m_since = 0;
        end
      end
    end
    if (c) begin
      m_err = 0; m_lkf = 0; m_plen = 0;
    end
  endtask

  // Compare process: step the model on each edge, check the DUT just after it.
  initial begin : compare_proc
    logic       v, c, r;
    logic [7:0] d;
    model_reset();
    forever begin
      @(posedge clk);
      v = bus.in_valid; d = bus.in_data; c = clr_stats; r = rst_n;
      if (!r) model_reset();
      else    model_step(v, d, c);
      #1;
      chk("cyc_locked",       locked,       m_locked);
      chk("cyc_err_pulse",    err_pulse,    m_ep);
      chk("cyc_err_count",    err_count,    m_err);
      chk("cyc_period_pulse", period_pulse, m_pp);
      chk("cyc_period_len",   period_len,   m_plen);
      chk("cyc_lockup_flag",  lockup_flag,  m_lkf);
    end
  end

  // ---------------- stimulus helpers (start and end on a falling edge) ----------------
  task automatic send(input logic [7:0] d, input logic clr);
    bus.in_valid = 1'b1; bus.in_data = d; clr_stats = clr;
    @(negedge clk);
    bus.in_valid = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0] g;
    logic [7:0] w;
    int         per;
    int         first;
    int         r;

    rst_n = 1'b0; clr_stats = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;

    // Pin the model's step function and period with hand-computed values.
    chk("pin_n01", nxt(8'h01), 8'h03);
    chk("pin_n0f", nxt(8'h0F), 8'h1E);
    chk("pin_n1e", nxt(8'h1E), 8'h3D);
    chk("pin_n3d", nxt(8'h3D), 8'h7A);
    chk("pin_nff", nxt(8'hFF), 8'hFF);
    g = 8'h01; per = 0;
    while (per < 600) begin
      g = nxt(g); per++;
      if (g == 8'h01) break;
    end
    chk("pin_period", per, 255);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_lockup", lockup_flag, 0);
    chk("rst_period_len", period_len, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lock-up sequence with gaps.
    g = 8'h01; send(g, 1'b0);
    for (int i = 0; i < 4; i++) begin
      gap(); g = nxt(g); send(g, 1'b0);
      if (i == 2) chk("lock_not_yet", locked, 0);
    end
    chk("lock_locked", locked, 1);
    chk("lock_err_count", err_count, 0);

    // Single error: 7C in place of 3D, then 7A still matches.
    gap(); g = nxt(g); send(8'h7C, 1'b0);
    chk("se_err_pulse", err_pulse, 1);
    chk("se_err_count", err_count, 1);
    chk("se_locked", locked, 1);
    gap(); g = nxt(g); send(g, 1'b0);
    chk("se_next_word", g, 8'h7A);
    chk("se_next_pulse", err_pulse, 0);
    chk("se_next_count", err_count, 1);

    // Clear, then three wrong words unlock.
    clr_pulse();
    chk("clr_err_count", err_count, 0);
    for (int i = 0; i < 3; i++) begin
      gap(); g = nxt(g); send(g ^ 8'h81, 1'b0);
      if (i < 2) chk("ul_still_locked", locked, 1);
    end
    chk("ul_locked", locked, 0);
    chk("ul_err_count", err_count, 3);

    // Five correct words relock.
    for (int i = 0; i < 5; i++) begin
      gap(); g = nxt(g); send(g, 1'b0);
      if (i == 3) chk("rl_not_yet", locked, 0);
    end
    chk("rl_locked", locked, 1);

    // Clear coinciding with a mismatch.
    gap(); g = nxt(g); send(g ^ 8'h10, 1'b1);
    chk("cm_err_pulse", err_pulse, 1);
    chk("cm_err_count", err_count, 0);
    chk("cm_locked", locked, 1);

    // Reset while locked: everything drops at once.
    rst_n = 1'b0;
    #1;
    chk("rm_locked", locked, 0);
    chk("rm_err_pulse", err_pulse, 0);
    chk("rm_err_count", err_count, 0);
    chk("rm_period_pulse", period_pulse, 0);
    chk("rm_period_len", period_len, 0);
    chk("rm_lockup", lockup_flag, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    g = 8'($urandom_range(0, 254));
    for (int i = 0; i < 5; i++) begin
      gap();
      if (i > 0) g = nxt(g);
      send(g, 1'b0);
      if (i == 3) chk("rm_relock_not_yet", locked, 0);
    end
    chk("rm_relock", locked, 1);

    // Full period from seed 01.
    do_reset();
    g = 8'h01; send(g, 1'b0);
    for (int i = 0; i < 4; i++) begin g = nxt(g); send(g, 1'b0); end
    chk("fp_locked", locked, 1);
    first = -1;
    for (int k = 1; k <= 300; k++) begin
      gap(); g = nxt(g); send(g, 1'b0);
      if (period_pulse && first < 0) first = k;
    end
    chk("fp_first_pulse", first, 255);
    chk("fp_period_len", period_len, 255);
    chk("fp_err_count", err_count, 0);

    // Stuck-high stream never locks but flags lockup.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      gap(); send(8'hFF, 1'b0);
      chk("st_locked", locked, 0);
    end
    chk("st_lockup", lockup_flag, 1);
    clr_pulse();
    chk("st_lockup_clr", lockup_flag, 0);

    // Randomized stream: mostly correct, with errors, lockup words, reseeds, clears.
    do_reset();
    g = 8'h01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        clr_stats = ($urandom_range(0, 49) == 0);
        @(negedge clk);
        clr_stats = 1'b0;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 85) begin
          g = nxt(g); w = g;
        end else if (r < 95) begin
          g = nxt(g); w = g ^ 8'($urandom_range(1, 255));
        end else if (r < 98) begin
          w = 8'hFF;
        end else begin
          g = 8'($urandom_range(0, 254)); w = g;
        end
        send(w, ($urandom_range(0, 99) == 0));
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
